ph_fifo_bank: RTL

//  Parametrised parasite-to-host FIFO bank for the Tube ULA: NUM_CH independent channels,

---
 rtl/ph_fifo_bank_pkg.sv | 34 +++
 rtl/ph_fifo_chan.sv | 89 ++++++++
 rtl/ph_fifo_bank.sv | 65 ++++++
 3 files changed

// File: rtl/ph_fifo_bank_pkg.sv
// Shared helpers for the parasite-to-host FIFO bank: width functions and the
// per-channel status bundle.
package ph_fifo_bank_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Pointer width, never narrower than one bit so DEPTH=1 still has a port.
    function automatic int ptr_w(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Count width: must hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic avail;
        logic full;
        logic overrun;
    } chan_stat_t;

endpackage

// File: rtl/ph_fifo_chan.sv
// One FIFO channel: storage, wrap-around pointers, occupancy count and
// status. Optional sticky overrun flag when PH_FIFO_OVERRUN_FLAG_EN is defined.
module ph_fifo_chan
    import ph_fifo_bank_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              push,
    input  logic              pop,
    input  logic              cap_one,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output chan_stat_t        stat
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cap;
    logic              full;
    logic              avail;
    logic              push_ok;
    logic              pop_ok;
    logic              overrun;

    // Capacity shrinks to one entry in one-byte mode; a count above the new
    // capacity simply keeps the channel full while it drains.
    assign cap     = cap_one ? CW'(1) : DEPTH_CNT;
    assign full    = (cnt >= cap);
    assign avail   = (cnt != '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & avail;

    // Pointer and count update; full/empty judged on the pre-edge count.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= (wptr == LAST_PTR) ? '0 : wptr + PW'(1);
            if (pop_ok)  rptr <= (rptr == LAST_PTR) ? '0 : rptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is data only; reset discards contents by clearing the count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

    assign head = avail ? mem[rptr] : '0;

`ifdef PH_FIFO_OVERRUN_FLAG_EN
    // Sticky flag for a push lost to a full channel; a new loss beats a clear.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            overrun <= 1'b0;
        end else if (push && full) begin
            overrun <= 1'b1;
        end else if (clr_err) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overrun        = 1'b0;
`endif

    assign stat.avail   = avail;
    assign stat.full    = full;
    assign stat.overrun = overrun;

endmodule

// File: rtl/ph_fifo_bank.sv
// Parasite-to-host FIFO bank: NUM_CH independent channels on the h_phi2 clock.
// Host select is priority-encoded (channel 0 wins). Channel FLEX_CH honours
// one_byte_mode. Optional macro: PH_FIFO_OVERRUN_FLAG_EN enables p_overrun.
module ph_fifo_bank
    import ph_fifo_bank_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 2,
    parameter int FLEX_CH = 2
) (
    input  logic              h_phi2,
    input  logic              h_rst_b,
    input  logic              p_we,
    input  logic [NUM_CH-1:0] p_sel,
    input  logic [DATA_W-1:0] p_data,
    input  logic              h_rd,
    input  logic [NUM_CH-1:0] h_sel,
    input  logic              one_byte_mode,
    output logic [DATA_W-1:0] h_data,
    output logic [NUM_CH-1:0] h_data_available,
    output logic              h_zero_bytes_available,
    output logic [NUM_CH-1:0] p_full,
    output logic [NUM_CH-1:0] p_overrun,
    input  logic              h_clr_err
);

    logic [NUM_CH-1:0] hsel_eff;
    logic [DATA_W-1:0] head [NUM_CH];
    chan_stat_t        stat [NUM_CH];

    // Isolate the lowest set bit of h_sel; zero select stays zero.
    assign hsel_eff = h_sel & (~h_sel + NUM_CH'(1));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        ph_fifo_chan #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_chan (
            .clk     (h_phi2),
            .rst_b   (h_rst_b),
            .push    (p_we & p_sel[g]),
            .pop     (h_rd & hsel_eff[g]),
            .cap_one (one_byte_mode & (g == FLEX_CH)),
            .clr_err (h_clr_err),
            .wdata   (p_data),
            .head    (head[g]),
            .stat    (stat[g])
        );
        assign h_data_available[g] = stat[g].avail;
        assign p_full[g]           = stat[g].full;
        assign p_overrun[g]        = stat[g].overrun;
    end

    assign h_zero_bytes_available = ~stat[FLEX_CH].avail;

    // Read mux: hsel_eff is one-hot or zero, so OR-ing the gated heads suffices.
    always_comb begin
        h_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hsel_eff[i]) h_data = h_data | head[i];
        end
    end

endmodule
